mem_bus_responder: RTL and testbench
====================================

# mem_bus_responder

Memory-side responder for the 16-bit RISC core's MAR/MDR memory interface. The control unit FSM asserts `mem_read` or `mem_write` while MAR drives `addr` and MDR drives `wdata`. This block services the request against an internal word-addressed array after a parameterised number of wait states, then returns `rdata` with a one-cycle `mem_ready` completion strobe. A side load port preloads programs and data before execution.

## Interface
- `ADDR_W`, 8 — implemented address bits; array depth is 2^ADDR_W words.
- `DATA_W`, 16 — word width.
- `WAIT_CYCLES`, 1 — wait states inserted before the array access; legal range 0..15.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `mem_read`  in  1  — read request, level; held until `mem_ready` is sampled high.
- `mem_write`  in  1  — write request, level; same rule as `mem_read`.
- `addr`  in  16  — word address from MAR.
- `wdata`  in  DATA_W  — write data from MDR.
- `rdata`  out  DATA_W  — read data toward MDR; holds the last successful read value.
- `mem_ready`  out  1  — one-cycle completion strobe.
- `busy`  out  1  — high while an access is in flight.
- `err`  out  1  — high together with `mem_ready` when a request was rejected.
- `prog_we`  in  1  — load-port write enable; honoured only in IDLE.
- `prog_addr`  in  ADDR_W  — load-port address.
- `prog_data`  in  DATA_W  — load-port data.

## Operation
- States are IDLE, WAIT, ACCESS and DONE.
- **IDLE**
  - If exactly one of `mem_read`/`mem_write` is high and `addr[15:ADDR_W]` is all zero, latch `addr[ADDR_W-1:0]`, `wdata` and the request type.
  - After latching, go to WAIT with the counter loaded to `WAIT_CYCLES`. If `WAIT_CYCLES`=0, go directly to ACCESS.
- **Invalid request in IDLE**
  - Covers both requests high together, or any nonzero upper address bit.
  - Go to DONE with `err` set. No array access occurs and `rdata` is unchanged.
- **WAIT**: decrement the counter each cycle; move to ACCESS on the cycle the counter reaches 1.
- **ACCESS**: a read loads `rdata` from the array; a write commits `wdata` into the array. Then go to DONE.
- **DONE**
  - `mem_ready`=1 for exactly one cycle; return to IDLE unconditionally.
  - The requester drops its request on the edge where it samples `mem_ready`. A request still high in the following IDLE cycle starts a new access.
- Request inputs are ignored in WAIT, ACCESS and DONE, because operands are already latched.
- `prog_we` outside IDLE is ignored; the write is dropped, not queued.
- `prog_we` together with an accepted request in IDLE: the load-port write commits at that edge, and the request still proceeds. A read of the same address returns the newly loaded data.
- Reset mid-operation forces IDLE. An uncommitted write is discarded. Array contents are not cleared.
- Reset values: `rdata`=0, `mem_ready`=0, `busy`=0, `err`=0, state IDLE, counter 0. Array contents are undefined after power-up.

## Timing
- Let E0 be the edge that samples a valid request in IDLE.
- `busy` is high from after E0 until DONE exits, i.e. during WAIT, ACCESS and DONE.
- The array write commits, or `rdata` updates, at edge E0+WAIT_CYCLES+1.
- `mem_ready` is high in the cycle after edge E0+WAIT_CYCLES+1. Request-to-ready latency is therefore WAIT_CYCLES+2 cycles, counted from the request cycle.
- Invalid request: `mem_ready`=`err`=1 in the cycle after E0, a latency of 2 cycles.
- `mem_ready`, `err` and `busy` are decoded from registered state, so none has a combinational path from any input.
- Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.

## Structure
- The shared package / include file holds:
  - the state encodings;
  - the `RSP_ST_*` constants;
  - the width of the `WAIT_CYCLES` counter (4 bits).
- Sub-module `mem_word_array` is a single-port synchronous array with one write port.
  - The responder muxes the write port between the load port (IDLE) and the access path (ACCESS). These can never conflict by construction.
  - Reads are registered into `rdata` by the responder.

## Test plan
- **Reset and idle:** reset asserted mid-WAIT of a write to 0x05 → IDLE immediately, all outputs 0, word 0x05 unchanged after release.
- **Load then read:** load 0x1234 at 0x10, then `mem_read` with addr=0x0010 and WAIT_CYCLES=1 → `mem_ready` 3 cycles after the request cycle, `rdata`=0x1234, `err`=0.
- **Write then read-back:** write 0xBEEF to 0x00FF (top address), then read 0x00FF → `rdata`=0xBEEF. Repeat with WAIT_CYCLES=0 → latency 2 cycles.
- **Invalid requests:**
  - `mem_read` and `mem_write` both high → `mem_ready`=`err`=1 after 2 cycles, `rdata` unchanged.
  - addr=0x0100 with ADDR_W=8 → same response, array untouched.
- **Request held and ignored inputs:**
  - Request held one extra cycle past `mem_ready` → a second access starts, `busy` rises again.
  - `prog_we` during WAIT → ignored; a later read shows the old data.
- **Simultaneous load-port and request:** `prog_we` writing 0xAAAA to 0x20 and `mem_read` of 0x20 in the same IDLE cycle → `rdata`=0xAAAA.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the MAR/MDR memory responder.
package mem_bus_responder_pkg;

    // Width of the wait-state counter (WAIT_CYCLES range 0..15).
    localparam int RSP_CNT_W = 4;

    typedef enum logic [1:0] {
        RSP_ST_IDLE   = 2'd0,
        RSP_ST_WAIT   = 2'd1,
        RSP_ST_ACCESS = 2'd2,
        RSP_ST_DONE   = 2'd3
    } rsp_state_e;

    // True when every address bit above the implemented range is zero.
    function automatic logic rsp_addr_in_range(input logic [15:0] a, input int unsigned aw);
        return (a >> aw) == 16'h0000;
    endfunction

endpackage

// File: rtl/mem_bus_responder_array.sv
// Single-port word array: one synchronous write port, asynchronous read of the same address.
module mem_word_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Commit a word on the rising edge when the write port is enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: services MAR/MDR read/write requests after WAIT_CYCLES wait states,
// with a side load port for preloading the array while idle.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam logic [RSP_CNT_W-1:0] WAIT_INIT = RSP_CNT_W'(WAIT_CYCLES);

    rsp_state_e           state, state_nxt;
    logic [RSP_CNT_W-1:0] cnt, cnt_nxt;
    logic                 err_q, err_nxt;
    logic                 latch_en;
    logic                 rdata_en;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic                 lat_write;
    logic                 req_ok;

    logic                 arr_we;
    logic [ADDR_W-1:0]    arr_addr;
    logic [DATA_W-1:0]    arr_wdata;
    logic [DATA_W-1:0]    arr_rdata;

    assign req_ok = (mem_read ^ mem_write) && rsp_addr_in_range(addr, ADDR_W);

    // Write port is owned by the load port in IDLE and by the access path in ACCESS only.
    mem_word_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // State, counter, latched operands and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RSP_ST_IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
            if (latch_en) begin
                lat_addr  <= addr[ADDR_W-1:0];
                lat_wdata <= wdata;
                lat_write <= mem_write;
            end
            if (rdata_en) begin
                rdata <= arr_rdata;
            end
        end
    end

    // Next-state, wait counter and array port control.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        latch_en  = 1'b0;
        rdata_en  = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = prog_addr;
        arr_wdata = prog_data;
        unique case (state)
            RSP_ST_IDLE: begin
                arr_we  = prog_we;
                err_nxt = 1'b0;
                if (mem_read || mem_write) begin
                    if (req_ok) begin
                        latch_en = 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_nxt = RSP_ST_ACCESS;
                        end else begin
                            state_nxt = RSP_ST_WAIT;
                            cnt_nxt   = WAIT_INIT;
                        end
                    end else begin
                        state_nxt = RSP_ST_DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            RSP_ST_WAIT: begin
                cnt_nxt = cnt - RSP_CNT_W'(1);
                if (cnt == RSP_CNT_W'(1)) begin
                    state_nxt = RSP_ST_ACCESS;
                end
            end
            RSP_ST_ACCESS: begin
                arr_addr  = lat_addr;
                arr_wdata = lat_wdata;
                arr_we    = lat_write;
                rdata_en  = !lat_write;
                state_nxt = RSP_ST_DONE;
            end
            RSP_ST_DONE: begin
                state_nxt = RSP_ST_IDLE;
            end
            default: begin
                state_nxt = RSP_ST_IDLE;
            end
        endcase
    end

    assign busy      = (state != RSP_ST_IDLE);
    assign mem_ready = (state == RSP_ST_DONE);
    assign err       = (state == RSP_ST_DONE) && err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomised and directed bench for mem_bus_responder, three instances with
// WAIT_CYCLES = 0, 1 and 3 sharing clock and reset.
module tb_mem_bus_responder;

    localparam int ND = 3;

    logic        clk;
    logic        rst_n;
    logic        mem_read  [ND];
    logic        mem_write [ND];
    logic [15:0] addr      [ND];
    logic [15:0] wdata     [ND];
    logic [15:0] rdata     [ND];
    logic        mem_ready [ND];
    logic        busy      [ND];
    logic        err       [ND];
    logic        prog_we   [ND];
    logic [7:0]  prog_addr [ND];
    logic [15:0] prog_data [ND];

    // Reference: plain memory image and last returned read word per instance.
    logic [15:0] model  [ND][256];
    logic [15:0] exp_rd [ND];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_bus_responder #(
            .ADDR_W      (8),
            .DATA_W      (16),
            .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .mem_read  (mem_read[g]),
            .mem_write (mem_write[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .rdata     (rdata[g]),
            .mem_ready (mem_ready[g]),
            .busy      (busy[g]),
            .err       (err[g]),
            .prog_we   (prog_we[g]),
            .prog_addr (prog_addr[g]),
            .prog_data (prog_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check_eq($sformatf("%s_ready_d%0d", tag, d), {31'b0, mem_ready[d]}, 32'd0);
        check_eq($sformatf("%s_busy_d%0d", tag, d), {31'b0, busy[d]}, 32'd0);
        check_eq($sformatf("%s_err_d%0d", tag, d), {31'b0, err[d]}, 32'd0);
    endtask

    task automatic load_word(input int d, input logic [7:0] a, input logic [15:0] v);
        @(negedge clk);
        prog_we[d] = 1'b1; prog_addr[d] = a; prog_data[d] = v;
        @(posedge clk);
        model[d][a] = v;
        @(negedge clk);
        prog_we[d] = 1'b0;
    endtask

    // pmode: 0 no load-port write, 1 load-port write at the request edge,
    // 2 load-port write one cycle after the request edge (must be dropped).
    task automatic do_req(input int d, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int pmode, input logic [7:0] pa, input logic [15:0] pd,
                          input logic hold);
        logic valid;
        int   n;
        valid = (rd ^ wr) && (a[15:8] == 8'h00);
        @(negedge clk);
        check_eq($sformatf("busy_pre_d%0d", d), {31'b0, busy[d]}, 32'd0);
        mem_read[d] = rd; mem_write[d] = wr; addr[d] = a; wdata[d] = wd;
        prog_we[d] = (pmode == 1); prog_addr[d] = pa; prog_data[d] = pd;
        @(posedge clk);
        if (pmode == 1) model[d][pa] = pd;
        if (valid && wr) model[d][a[7:0]] = wd;
        if (valid && rd) exp_rd[d] = model[d][a[7:0]];
        #1;
        n = 0;
        while (mem_ready[d] !== 1'b1 && n < 40) begin
            check_eq($sformatf("busy_wait_d%0d", d), {31'b0, busy[d]}, 32'd1);
            @(negedge clk);
            prog_we[d] = (pmode == 2 && n == 0);
            @(posedge clk);
            #1;
            n++;
        end
        check_eq($sformatf("latency_d%0d", d), n, valid ? wait_of(d) + 1 : 0);
        check_eq($sformatf("busy_done_d%0d", d), {31'b0, busy[d]}, 32'd1);
        check_eq($sformatf("err_d%0d", d), {31'b0, err[d]}, {31'b0, !valid});
        check_eq($sformatf("rdata_d%0d", d), {16'b0, rdata[d]}, {16'b0, exp_rd[d]});
        @(negedge clk);
        prog_we[d] = 1'b0;
        if (!hold) begin
            mem_read[d] = 1'b0; mem_write[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        check_idle_outputs(d, "post");
    endtask

    initial begin
        logic [15:0] v;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            mem_read[d] = 1'b0; mem_write[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            prog_we[d] = 1'b0; prog_addr[d] = '0; prog_data[d] = '0;
            exp_rd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check_idle_outputs(d, "reset");
            check_eq($sformatf("reset_rdata_d%0d", d), {16'b0, rdata[d]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every word through the load port so the model is fully defined.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                v = 16'($urandom);
                prog_we[d] = 1'b1; prog_addr[d] = 8'(i); prog_data[d] = v;
                model[d][i] = v;
            end
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) prog_we[d] = 1'b0;

        // Load then read.
        load_word(1, 8'h10, 16'h1234);
        do_req(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 8'h00, 16'h0000, 1'b0);
        check_eq("load_read_value", {16'b0, rdata[1]}, 32'h0000_1234);

        // Write then read back at the top address.
        for (int d = 0; d < 2; d++) begin
            do_req(d, 1'b0, 1'b1, 16'h00FF, 16'hBEEF, 0, 8'h00, 16'h0000, 1'b0);
            do_req(d, 1'b1, 1'b0, 16'h00FF, 16'h0000, 0, 8'h00, 16'h0000, 1'b0);
            check_eq($sformatf("top_addr_value_d%0d", d), {16'b0, rdata[d]}, 32'h0000_BEEF);
        end

        // Invalid requests: both strobes, then an out-of-range write aliasing word 0.
        for (int d = 0; d < ND; d++) begin
            do_req(d, 1'b1, 1'b1, 16'h0010, 16'h5555, 0, 8'h00, 16'h0000, 1'b0);
            do_req(d, 1'b0, 1'b1, 16'h0100, 16'hDEAD, 0, 8'h00, 16'h0000, 1'b0);
            do_req(d, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 8'h00, 16'h0000, 1'b0);
        end

        // Request held past mem_ready starts a second access.
        do_req(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 8'h00, 16'h0000, 1'b1);
        do_req(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 8'h00, 16'h0000, 1'b0);

        // Load-port write while busy is dropped.
        do_req(2, 1'b1, 1'b0, 16'h0030, 16'h0000, 2, 8'h30, ~model[2][8'h30], 1'b0);
        do_req(2, 1'b1, 1'b0, 16'h0030, 16'h0000, 0, 8'h00, 16'h0000, 1'b0);

        // Load-port write and read of the same word in one IDLE cycle.
        do_req(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1, 8'h20, 16'hAAAA, 1'b0);
        check_eq("same_cycle_load_read", {16'b0, rdata[1]}, 32'h0000_AAAA);

        // Reset in the middle of the wait states of a write to 0x05.
        @(negedge clk);
        mem_write[2] = 1'b1; addr[2] = 16'h0005; wdata[2] = ~model[2][5];
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("pre_reset_busy", {31'b0, busy[2]}, 32'd1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check_idle_outputs(d, "midreset");
            check_eq($sformatf("midreset_rdata_d%0d", d), {16'b0, rdata[d]}, 32'd0);
            exp_rd[d] = '0;
        end
        mem_write[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(2, 1'b1, 1'b0, 16'h0005, 16'h0000, 0, 8'h00, 16'h0000, 1'b0);

        // Random traffic against the reference image.
        for (int d = 0; d < ND; d++) begin
            for (int t = 0; t < 40; t++) begin
                int unsigned kind;
                logic rd, wr, valid, hold;
                logic [15:0] a;
                int pm;
                kind = $urandom_range(0, 8);
                rd = (kind <= 3) || (kind == 8);
                wr = (kind >= 4);
                a = {8'h00, 8'($urandom)};
                if ($urandom_range(0, 7) == 0) a[15:8] = 8'($urandom_range(1, 255));
                valid = (rd ^ wr) && (a[15:8] == 8'h00);
                pm = $urandom_range(0, 5);
                if (pm > 2 || (pm == 2 && !valid)) pm = 0;
                hold = valid && ($urandom_range(0, 7) == 0);
                do_req(d, rd, wr, a, 16'($urandom), pm, 8'($urandom), 16'($urandom), hold);
                if (hold) do_req(d, rd, wr, a, wdata[d], 0, 8'h00, 16'h0000, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
